tpu_seq_controller: RTL and testbench

Parametrised instruction-sequencing controller for the TinyTPU datapath; successor to the fixed 4-row controller. Fetches instructions from the instruction buffer with a valid handshake, decodes MOVE / PRELOAD / COMPUTE / HALT, and drives the shared-memory, buffer, PE-array and elementwise-array enables with address streams for ARRAY_N-row bursts. Beyond the fixed-size controller it adds a configurable array size, a compute watchdog, synchronous abort, and busy/done/err status.

---
 rtl/tpu_ctrl_pkg.sv | 46 ++++
 rtl/ctrl_burst_cnt.sv | 23 ++
 rtl/tpu_seq_controller.sv | 194 +++++++++++++++++++
 tb/tb_tpu_seq_controller.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_ctrl_pkg.sv
// Shared state encoding, instruction words, region tags and enable bit positions
// for the TinyTPU instruction-sequencing controller.
package tpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_DISPATCH  = 4'd3,
    ST_PRELOAD   = 4'd4,
    ST_MOVE      = 4'd5,
    ST_COMPUTE   = 4'd6,
    ST_WRITEBACK = 4'd7
  } state_t;

  // Instruction words are compared as {opcode, func}.
  localparam logic [7:0] INS_MOVE      = 8'h11;
  localparam logic [7:0] INS_PRELOAD_A = 8'h12;
  localparam logic [7:0] INS_PRELOAD_B = 8'h22;
  localparam logic [7:0] INS_COMPUTE   = 8'h14;
  localparam logic [7:0] INS_HALT      = 8'hFF;

  localparam logic [3:0] TAG_SHM   = 4'b0001;
  localparam logic [3:0] TAG_INBUF = 4'b0010;
  localparam logic [3:0] TAG_WBUF  = 4'b0100;

  localparam logic [1:0] REG_NONE  = 2'd0;
  localparam logic [1:0] REG_SHM   = 2'd1;
  localparam logic [1:0] REG_INBUF = 2'd2;
  localparam logic [1:0] REG_WBUF  = 2'd3;

  localparam int EN_REN     = 1;
  localparam int EN_WEN     = 0;
  localparam int PE_PRELOAD = 1;
  localparam int PE_COMPUTE = 0;

  function automatic logic [1:0] region_code(input logic [3:0] tag);
    case (tag)
      TAG_SHM:   return REG_SHM;
      TAG_INBUF: return REG_INBUF;
      TAG_WBUF:  return REG_WBUF;
      default:   return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_burst_cnt.sv
// Burst cycle counter shared by the MOVE, PRELOAD and WRITEBACK bursts;
// term flags the final (ARRAY_N-th) count.
module ctrl_burst_cnt #(
  parameter int ARRAY_N = 4,
  parameter int CNT_W   = $clog2(ARRAY_N + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

  assign term = (cnt == CNT_W'(ARRAY_N));

endmodule

// File: rtl/tpu_seq_controller.sv
// Instruction sequencer for the TinyTPU datapath: fetch/decode/dispatch plus
// ARRAY_N-row MOVE, PRELOAD and WRITEBACK bursts and a watchdogged COMPUTE.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start; done/err hold the last program's result
// FETCH     | insbuf read strobe held until the buffer presents valid
// DECODE    | one-cycle decoder enable
// DISPATCH  | latch addresses/regions, bump pc, pick the next phase
// PRELOAD   | shm read stream feeding PE preload, one cycle behind
// MOVE      | shm read stream copied into inbuf or wbuf, one cycle behind
// COMPUTE   | PE array running until compute_finished or watchdog expiry
// WRITEBACK | elementwise results written back to shm, one cycle behind
module tpu_seq_controller
  import tpu_ctrl_pkg::*;
#(
  parameter int ARRAY_N     = 4,
  parameter int ADDR_W      = 6,
  parameter int PC_W        = 8,
  parameter int CMP_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              instr_valid,
  input  logic [3:0]        func,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W+3:0] rs1,
  input  logic [ADDR_W+3:0] rs2,
  input  logic              compute_finished,
  output logic [1:0]        shm_en,
  output logic [1:0]        inbuf_en,
  output logic [1:0]        wbuf_en,
  output logic [1:0]        pe_en,
  output logic              ele_en,
  output logic              insbuf_ren,
  output logic              decoder_en,
  output logic [PC_W-1:0]   pc,
  output logic [3:0]        state,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic [ADDR_W-1:0] addr_result,
  output logic [1:0]        source,
  output logic [1:0]        target,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(ARRAY_N + 1);
  localparam int WD_W  = $clog2(CMP_TIMEOUT + 1);

  state_t           st_q;
  logic [CNT_W-1:0] cnt;
  logic             term;
  logic             in_burst;
  logic             rd_phase;
  logic             wr_phase;
  logic [WD_W-1:0]  wd_cnt;
  logic [7:0]       instr;
  logic [1:0]       src_code;
  logic [1:0]       tgt_code;

  assign instr    = {opcode, func};
  assign src_code = region_code(rs1[ADDR_W+3:ADDR_W]);
  assign tgt_code = region_code(rs2[ADDR_W+3:ADDR_W]);
  assign in_burst = (st_q == ST_PRELOAD) || (st_q == ST_MOVE) || (st_q == ST_WRITEBACK);
  assign rd_phase = !term;
  assign wr_phase = (cnt != '0);

  ctrl_burst_cnt #(.ARRAY_N(ARRAY_N), .CNT_W(CNT_W)) u_burst_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (!in_burst || term),
    .en    (in_burst),
    .cnt   (cnt),
    .term  (term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= ST_IDLE;
      pc          <= '0;
      addr1       <= '0;
      addr2       <= '0;
      addr_result <= '0;
      source      <= REG_NONE;
      target      <= REG_NONE;
      done        <= 1'b0;
      err         <= 1'b0;
      wd_cnt      <= '0;
    end else if (abort) begin
      st_q <= ST_IDLE;
    end else begin
      case (st_q)
        ST_IDLE: if (start) begin
          st_q <= ST_FETCH;
          pc   <= '0;
          done <= 1'b0;
          err  <= 1'b0;
        end
        ST_FETCH:  if (instr_valid) st_q <= ST_DECODE;
        ST_DECODE: st_q <= ST_DISPATCH;
        ST_DISPATCH: begin
          addr1       <= rs1[ADDR_W-1:0];
          addr2       <= rs2[ADDR_W-1:0];
          addr_result <= rs2[ADDR_W-1:0];
          source      <= src_code;
          target      <= tgt_code;
          wd_cnt      <= WD_W'(CMP_TIMEOUT - 1);
          if (instr != INS_HALT) pc <= pc + PC_W'(1);
          case (instr)
            INS_PRELOAD_A, INS_PRELOAD_B: st_q <= ST_PRELOAD;
            INS_MOVE:
              if (tgt_code == REG_INBUF || tgt_code == REG_WBUF) st_q <= ST_MOVE;
              else begin
                st_q <= ST_IDLE;
                err  <= 1'b1;
              end
            INS_COMPUTE: st_q <= ST_COMPUTE;
            INS_HALT: begin
              st_q <= ST_IDLE;
              done <= 1'b1;
            end
            default: begin
              st_q <= ST_IDLE;
              err  <= 1'b1;
            end
          endcase
        end
        ST_PRELOAD: begin
          if (rd_phase) addr1 <= addr1 + ADDR_W'(1);
          if (term) st_q <= ST_FETCH;
        end
        ST_MOVE: begin
          if (rd_phase) addr1 <= addr1 + ADDR_W'(1);
          if (wr_phase) addr2 <= addr2 + ADDR_W'(1);
          if (term) st_q <= ST_FETCH;
        end
        // A finish arriving on the expiry cycle still counts as success.
        ST_COMPUTE: begin
          if (compute_finished) st_q <= ST_WRITEBACK;
          else if (wd_cnt == '0) begin
            st_q <= ST_IDLE;
            err  <= 1'b1;
          end else wd_cnt <= wd_cnt - WD_W'(1);
        end
        ST_WRITEBACK: begin
          if (wr_phase) addr_result <= addr_result + ADDR_W'(1);
          if (term) st_q <= ST_FETCH;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    shm_en     = '0;
    inbuf_en   = '0;
    wbuf_en    = '0;
    pe_en      = '0;
    ele_en     = 1'b0;
    insbuf_ren = 1'b0;
    decoder_en = 1'b0;
    case (st_q)
      ST_FETCH:  insbuf_ren = 1'b1;
      ST_DECODE: decoder_en = 1'b1;
      ST_PRELOAD: begin
        shm_en[EN_REN]    = rd_phase;
        pe_en[PE_PRELOAD] = wr_phase;
      end
      ST_MOVE: begin
        shm_en[EN_REN]   = rd_phase;
        inbuf_en[EN_WEN] = wr_phase && (target == REG_INBUF);
        wbuf_en[EN_WEN]  = wr_phase && (target == REG_WBUF);
      end
      ST_COMPUTE: begin
        inbuf_en[EN_REN]  = 1'b1;
        wbuf_en[EN_REN]   = 1'b1;
        pe_en[PE_COMPUTE] = 1'b1;
      end
      ST_WRITEBACK: begin
        ele_en         = rd_phase;
        shm_en[EN_WEN] = wr_phase;
      end
      default: ;
    endcase
  end

  assign state = st_q;
  assign busy  = (st_q != ST_IDLE);

endmodule

// File: tb/tb_tpu_seq_controller.sv
// Directed plus randomized bench for tpu_seq_controller, checked against an
// instruction-level model of pc, status flags and per-cycle burst streams.
module tb_tpu_seq_controller;

  localparam int N  = 4;
  localparam int AW = 6;
  localparam int PW = 8;
  localparam int CT = 8;
  localparam int K_MOVE = 0, K_PRE = 1, K_CMP = 2, K_HALT = 3, K_ERR = 4;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
  logic instr_valid = 1'b0, compute_finished = 1'b0;
  logic [3:0] func = '0, opcode = '0;
  logic [AW+3:0] rs1 = '0, rs2 = '0;
  logic [1:0] shm_en, inbuf_en, wbuf_en, pe_en, source, target;
  logic ele_en, insbuf_ren, decoder_en, busy, done, err;
  logic [PW-1:0] pc;
  logic [3:0] state;
  logic [AW-1:0] addr1, addr2, addr_result;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int m_pc;
  bit m_done, m_err;

  always #5 clk = ~clk;

  tpu_seq_controller #(.ARRAY_N(N), .ADDR_W(AW), .PC_W(PW), .CMP_TIMEOUT(CT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .instr_valid(instr_valid),
    .func(func), .opcode(opcode), .rs1(rs1), .rs2(rs2), .compute_finished(compute_finished),
    .shm_en(shm_en), .inbuf_en(inbuf_en), .wbuf_en(wbuf_en), .pe_en(pe_en), .ele_en(ele_en),
    .insbuf_ren(insbuf_ren), .decoder_en(decoder_en), .pc(pc), .state(state),
    .addr1(addr1), .addr2(addr2), .addr_result(addr_result), .source(source),
    .target(target), .busy(busy), .done(done), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tcode(input logic [3:0] tag);
    case (tag)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int classify(input logic [3:0] op, input logic [3:0] fn, input logic [AW+3:0] r2);
    if ((op == 1 && fn == 2) || (op == 2 && fn == 2)) return K_PRE;
    if (op == 1 && fn == 1) return (tcode(r2[AW+3:AW]) inside {2, 3}) ? K_MOVE : K_ERR;
    if (op == 1 && fn == 4) return K_CMP;
    if (op == 4'hF && fn == 4'hF) return K_HALT;
    return K_ERR;
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_pc = 0; m_done = 0; m_err = 0;
    chk("start_state", state, 1);
    chk("start_busy", busy, 1);
    chk("start_pc", pc, 0);
    chk("start_done", done, 0);
    chk("start_err", err, 0);
  endtask

  // Walks FETCH (with vd stalled cycles), DECODE, DISPATCH; ends in the cycle after DISPATCH.
  task automatic front(input logic [3:0] op, input logic [3:0] fn,
                       input logic [AW+3:0] r1, input logic [AW+3:0] r2, input int vd);
    chk("fetch_state", state, 1);
    opcode = op; func = fn; rs1 = r1; rs2 = r2; instr_valid = 1'b0;
    for (int i = 0; i < vd; i++) begin
      chk("fetch_wait_ren", insbuf_ren, 1);
      chk("fetch_wait_nodec", decoder_en, 0);
      tick();
      chk("fetch_wait_state", state, 1);
    end
    chk("fetch_ren", insbuf_ren, 1);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("decode_state", state, 2);
    chk("decode_en", decoder_en, 1);
    tick();
    chk("dispatch_state", state, 3);
    chk("dispatch_nodec", decoder_en, 0);
    tick();
    if (!(op == 4'hF && fn == 4'hF)) m_pc = (m_pc + 1) % (1 << PW);
    chk("pc", pc, m_pc);
    chk("addr1_latch", addr1, r1[AW-1:0]);
    chk("addr2_latch", addr2, r2[AW-1:0]);
    chk("addr_result_latch", addr_result, r2[AW-1:0]);
    chk("source", source, tcode(r1[AW+3:AW]));
    chk("target", target, tcode(r2[AW+3:AW]));
  endtask

  // cmp_at: COMPUTE cycle carrying compute_finished (0 = never); abort_wb: WRITEBACK cycle to abort (-1 = none).
  task automatic body(input int kind, input logic [AW+3:0] r1, input logic [AW+3:0] r2,
                      input int cmp_at, input int abort_wb, output bit idle_end);
    int a1, a2, tc, nrd, nwr;
    bit fin;
    a1 = int'(r1[AW-1:0]); a2 = int'(r2[AW-1:0]); tc = tcode(r2[AW+3:AW]);
    nrd = 0; nwr = 0; fin = 0;
    idle_end = 1'b1;
    case (kind)
      K_HALT: begin
        m_done = 1;
        chk("halt_state", state, 0);
        chk("halt_done", done, 1);
        chk("halt_err", err, m_err);
        chk("halt_busy", busy, 0);
      end
      K_ERR: begin
        m_err = 1;
        chk("illegal_state", state, 0);
        chk("illegal_err", err, 1);
        chk("illegal_done", done, m_done);
        chk("illegal_busy", busy, 0);
      end
      K_MOVE, K_PRE: begin
        for (int k = 0; k <= N; k++) begin
          bit rd, wr;
          rd = (k < N); wr = (k >= 1);
          chk("burst_state", state, (kind == K_MOVE) ? 5 : 4);
          chk("burst_shm", shm_en, rd ? 2 : 0);
          if (kind == K_MOVE) begin
            chk("move_inbuf", inbuf_en, (wr && tc == 2) ? 1 : 0);
            chk("move_wbuf", wbuf_en, (wr && tc == 3) ? 1 : 0);
            chk("move_pe", pe_en, 0);
            if (wr) chk("move_addr2", addr2, (a2 + k - 1) % (1 << AW));
          end else begin
            chk("pre_pe", pe_en, wr ? 2 : 0);
            chk("pre_inbuf", inbuf_en, 0);
            chk("pre_wbuf", wbuf_en, 0);
          end
          if (rd) chk("burst_addr1", addr1, (a1 + k) % (1 << AW));
          if (shm_en[1]) nrd++;
          if (inbuf_en[0] || wbuf_en[0] || pe_en[1]) nwr++;
          tick();
        end
        chk("burst_reads", nrd, N);
        chk("burst_writes", nwr, N);
        chk("burst_exit_fetch", state, 1);
        idle_end = 1'b0;
      end
      K_CMP: begin
        for (int c = 1; c <= CT; c++) begin
          chk("cmp_state", state, 6);
          chk("cmp_pe", pe_en, 1);
          chk("cmp_inbuf", inbuf_en, 2);
          chk("cmp_wbuf", wbuf_en, 2);
          chk("cmp_shm", shm_en, 0);
          compute_finished = (c == cmp_at);
          tick();
          compute_finished = 1'b0;
          if (c == cmp_at) begin
            fin = 1;
            break;
          end
        end
        if (!fin) begin
          m_err = 1;
          chk("timeout_state", state, 0);
          chk("timeout_err", err, 1);
          chk("timeout_pe", pe_en, 0);
        end else begin
          for (int k = 0; k <= N; k++) begin
            if (k == abort_wb) begin
              abort = 1'b1;
              tick();
              abort = 1'b0;
              chk("abort_state", state, 0);
              chk("abort_pc", pc, m_pc);
              chk("abort_err", err, m_err);
              chk("abort_done", done, m_done);
              for (int j = 0; j < 3; j++) begin
                chk("abort_no_wen", shm_en, 0);
                chk("abort_no_ele", ele_en, 0);
                tick();
              end
              return;
            end
            chk("wb_state", state, 7);
            chk("wb_ele", ele_en, (k < N) ? 1 : 0);
            chk("wb_shm", shm_en, (k >= 1) ? 1 : 0);
            if (k >= 1) chk("wb_addr_result", addr_result, (a2 + k - 1) % (1 << AW));
            tick();
          end
          chk("wb_exit_fetch", state, 1);
          idle_end = 1'b0;
        end
      end
      default: ;
    endcase
  endtask

  task automatic instr(input logic [3:0] op, input logic [3:0] fn, input logic [AW+3:0] r1,
                       input logic [AW+3:0] r2, input int vd, input int cmp_at,
                       input int abort_wb, output bit idle_end);
    front(op, fn, r1, r2, vd);
    body(classify(op, fn, r2), r1, r2, cmp_at, abort_wb, idle_end);
  endtask

  function automatic logic [AW+3:0] rnd_reg();
    logic [3:0] tags [5];
    tags = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    return {tags[$urandom_range(0, 4)], AW'($urandom_range(0, (1 << AW) - 1))};
  endfunction

  initial begin
    bit ie;
    logic [PW-1:0] pc_hold;
    #2;
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_enables", {shm_en, inbuf_en, wbuf_en, pe_en, ele_en, insbuf_ren, decoder_en}, 0);
    chk("rst_regs", {pc, addr1, addr2, addr_result, source, target, done, err}, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("idle_ignores_valid", state, 0);

    do_start();
    instr(4'h1, 4'h1, {4'b0001, 6'd5}, {4'b0010, 6'd10}, 0, 0, -1, ie);
    chk("move_pc", pc, 1);
    instr(4'h1, 4'h2, {4'b0001, 6'd62}, {4'b0100, 6'd3}, 5, 0, -1, ie);
    instr(4'h1, 4'h4, {4'b0010, 6'd0}, {4'b0001, 6'd20}, 0, 7, -1, ie);
    instr(4'h2, 4'h2, {4'b0001, 6'd60}, {4'b0100, 6'd1}, 1, 0, -1, ie);
    instr(4'h1, 4'h1, {4'b0001, 6'd61}, {4'b0100, 6'd63}, 0, 0, -1, ie);
    instr(4'hF, 4'hF, {4'b0001, 6'd7}, {4'b0001, 6'd9}, 2, 0, -1, ie);
    pc_hold = pc;
    tick(); tick();
    chk("halt_pc_frozen", pc, pc_hold);
    chk("halt_done_sticky", done, 1);

    do_start();
    instr(4'h3, 4'h3, {4'b0001, 6'd1}, {4'b0010, 6'd2}, 0, 0, -1, ie);
    tick();
    chk("err_sticky", err, 1);
    do_start();
    instr(4'h1, 4'h1, {4'b0001, 6'd1}, {4'b0001, 6'd2}, 0, 0, -1, ie);
    do_start();
    instr(4'h1, 4'h4, {4'b0010, 6'd0}, {4'b0001, 6'd30}, 0, 0, -1, ie);
    do_start();
    instr(4'h1, 4'h4, {4'b0010, 6'd0}, {4'b0001, 6'd40}, 0, CT, -1, ie);
    instr(4'h1, 4'h4, {4'b0010, 6'd0}, {4'b0001, 6'd50}, 0, 3, 2, ie);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_beats_start", state, 0);
    do_start();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_fetch", state, 0);

    do_start();
    front(4'h1, 4'h1, {4'b0001, 6'd5}, {4'b0010, 6'd10}, 0);
    tick(); tick();
    chk("pre_reset_shm", shm_en, 2);
    chk("pre_reset_inbuf", inbuf_en, 1);
    reset = 1'b0;
    #1;
    chk("mid_reset_state", state, 0);
    chk("mid_reset_enables", {shm_en, inbuf_en, wbuf_en, pe_en, ele_en, insbuf_ren, decoder_en}, 0);
    chk("mid_reset_regs", {pc, addr1, addr2, addr_result, source, target, busy, done, err}, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    for (int p = 0; p < 25; p++) begin
      do_start();
      ie = 1'b0;
      for (int s = 0; s < 6 && !ie; s++) begin
        logic [3:0] op, fn;
        int sel, ca, ab;
        sel = $urandom_range(0, 5);
        case (sel)
          0: begin op = 1; fn = 1; end
          1: begin op = 1; fn = 2; end
          2: begin op = 2; fn = 2; end
          3: begin op = 1; fn = 4; end
          4: begin op = 4'hF; fn = 4'hF; end
          default: begin op = 4'($urandom_range(0, 15)); fn = 4'($urandom_range(0, 15)); end
        endcase
        ca = $urandom_range(1, CT + 1);
        if (ca > CT) ca = 0;
        ab = ($urandom_range(0, 7) == 0) ? $urandom_range(0, N) : -1;
        instr(op, fn, rnd_reg(), rnd_reg(), $urandom_range(0, 3), ca, ab, ie);
      end
      if (!ie) instr(4'hF, 4'hF, rnd_reg(), rnd_reg(), 0, 0, -1, ie);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
